uart_tx_arbiter: RTL and testbench

- Shares the single uart_tx serializer between NREQ bus-side requesters, such as several bus_to_uart bridges or a debug port.
- Sits between the requesters and uart_tx: drives uart_tx data_in and tx_external, and observes uart_busy.
- Grants byte by byte using round-robin priority.
- A requester can lock the transmitter across a multi-byte message.
- Detects a serializer that never starts (start timeout).

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 38 +++
 rtl/uart_tx_arbiter_rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared constants for the uart_tx arbiter: FSM state encoding, state width,
// and default parameter values. No ports.
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] START     = 2'd1;
    localparam logic [STATE_W-1:0] WAIT_BUSY = 2'd2;
    localparam logic [STATE_W-1:0] WAIT_IDLE = 2'd3;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_N        = 8;
    localparam int DEF_START_TO = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and the uart_tx side of the arbiter.
//   req, lock, req_data : requester byte requests, lock flags and data
//   byte_ack, gnt       : per-requester commit pulse and current owner
//   to_uart, tx_external: byte and start strobe towards uart_tx
//   uart_busy           : serializer busy, from uart_tx
//   err, state_out      : start-timeout pulse and FSM state (debug)
// master = requesters + serializer side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int N    = 8
);
    import uart_arb_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*N-1:0]  req_data;
    logic [NREQ-1:0]    byte_ack;
    logic [NREQ-1:0]    gnt;
    logic [N-1:0]       to_uart;
    logic               tx_external;
    logic               uart_busy;
    logic               err;
    logic [STATE_W-1:0] state_out;

    modport master (
        output req, lock, req_data, uart_busy,
        input  byte_ack, gnt, to_uart, tx_external, err, state_out
    );

    modport slave (
        input  req, lock, req_data, uart_busy,
        output byte_ack, gnt, to_uart, tx_external, err, state_out
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: first set bit of req_i starting at
// ptr_i+1, wrapping modulo NREQ.
//   req_i : request vector
//   ptr_i : index of the last winner
//   idx_o : winning index (0 when none)
//   vld_o : at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                vld_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx serializer between NREQ requesters, byte by byte, with
// round-robin priority, optional message lock and a start timeout.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of uart_tx_arbiter_if (requests, grants, uart_tx link)
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int N        = DEF_N,
    parameter int START_TO = DEF_START_TO
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(START_TO + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [N-1:0]       to_uart_q, to_uart_d;
    logic               tx_q, tx_d;
    logic               err_q, err_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               lockv_q, lockv_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic               sel;
    logic [IW-1:0]      sel_idx;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        to_uart_d = to_uart_q;
        tx_d      = 1'b0;
        err_d     = 1'b0;
        ptr_d     = ptr_q;
        lockv_d   = lockv_q;
        timer_d   = timer_q;
        sel       = 1'b0;
        sel_idx   = win_idx;

        case (state_q)
            IDLE: begin
                // Never start while the serializer is still busy (e.g. after
                // a reset that landed mid-byte).
                if (!bus.uart_busy) begin
                    if (lockv_q) begin
                        // ptr_q is the lock owner: it won the previous byte.
                        if (bus.req[ptr_q]) begin
                            sel     = 1'b1;
                            sel_idx = ptr_q;
                        end else if (!bus.lock[ptr_q]) begin
                            lockv_d = 1'b0;
                        end
                    end else if (win_vld) begin
                        sel = 1'b1;
                    end
                    // tx/ack flops are loaded here so they are high during START.
                    if (sel) begin
                        gnt_d          = '0;
                        gnt_d[sel_idx] = 1'b1;
                        ack_d          = gnt_d;
                        to_uart_d      = bus.req_data[int'(sel_idx)*N +: N];
                        ptr_d          = sel_idx;
                        tx_d           = 1'b1;
                        state_d        = START;
                    end
                end
            end
            START: begin
                lockv_d = bus.lock[ptr_q];
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.uart_busy) begin
                    state_d = WAIT_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    // err lands in the cycle the timer becomes START_TO-1.
                    if (timer_q == TW'(START_TO - 2)) begin
                        err_d   = 1'b1;
                        lockv_d = 1'b0;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!bus.uart_busy) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            to_uart_q <= '0;
            tx_q      <= 1'b0;
            err_q     <= 1'b0;
            ptr_q     <= IW'(NREQ - 1);
            lockv_q   <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            to_uart_q <= to_uart_d;
            tx_q      <= tx_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            lockv_q   <= lockv_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.byte_ack    = ack_q;
    assign bus.to_uart     = to_uart_q;
    assign bus.tx_external = tx_q;
    assign bus.err         = err_q;
    assign bus.state_out   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NREQ=4, N=8, START_TO=16) with a small
// uart_tx busy model: busy rises one cycle after tx_external, lasts 10 cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic clk;
    logic reset;
    logic busy_m;
    logic busy_force;
    logic busy_en;
    int   bcnt;
    logic pend;
    int   chk_cnt;
    int   pass_cnt;

    uart_tx_arbiter_if #(.NREQ(4), .N(8)) bus ();

    uart_tx_arbiter #(.NREQ(4), .N(8), .START_TO(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.uart_busy = busy_m | busy_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model, updated 2ns after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (!busy_en) begin
            busy_m = 1'b0; pend = 1'b0; bcnt = 0;
        end else if (bus.tx_external) begin
            pend = 1'b1;
        end else if (pend) begin
            pend = 1'b0; busy_m = 1'b1; bcnt = 10;
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) busy_m = 1'b0;
        end
    end

    task automatic wait_ack(output logic ok, output logic [3:0] ack,
                            output logic [3:0] g, output logic [7:0] d);
        ok = 1'b0; ack = '0; g = '0; d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx_external) begin
                ok = 1'b1; ack = bus.byte_ack; g = bus.gnt; d = bus.to_uart;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.state_out == 2'd0 && !bus.uart_busy && bus.gnt == 4'b0) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({bus.gnt, bus.byte_ack, bus.to_uart, bus.tx_external, bus.err, bus.state_out} !== 20'h0)
            $display("FAIL reset_outputs: got gnt=%b ack=%b to_uart=%h tx=%b err=%b st=%0d, want all 0",
                     bus.gnt, bus.byte_ack, bus.to_uart, bus.tx_external, bus.err, bus.state_out);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int bad;
        int seen;
        bus.req_data[7:0] = 8'h5A;
        bus.req = 4'b0001;
        #1;
        chk_cnt++;
        if (bus.tx_external !== 1'b0) $display("FAIL single_tx_early: got %b want 0", bus.tx_external);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.tx_external !== 1'b1) $display("FAIL single_latency: tx got %b want 1", bus.tx_external);
        else pass_cnt++;
        chk_cnt++;
        if (bus.to_uart !== 8'h5A) $display("FAIL single_data: got %h want 5a", bus.to_uart);
        else pass_cnt++;
        chk_cnt++;
        if (bus.byte_ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", bus.byte_ack);
        else pass_cnt++;
        chk_cnt++;
        if (bus.state_out !== 2'd1) $display("FAIL single_start_state: got %0d want 1", bus.state_out);
        else pass_cnt++;
        bus.req = 4'b0000;
        bad = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.uart_busy) seen++;
            if (bus.gnt !== 4'b0001) bad++;
            if (seen > 0 && !bus.uart_busy) break;
        end
        chk_cnt++;
        if (bad != 0 || seen != 10)
            $display("FAIL single_gnt_held: bad gnt cycles %0d busy cycles %0d, want 0 and 10", bad, seen);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.gnt !== 4'b0 || bus.state_out !== 2'd0)
            $display("FAIL single_release: gnt=%b st=%0d want 0000 and 0", bus.gnt, bus.state_out);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic ok; logic [3:0] a; logic [3:0] g; logic [7:0] d;
        logic [3:0] eg;
        do_reset();
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            wait_ack(ok, a, g, d);
            if (b == 4) bus.req = 4'b0000;
            eg = 4'b0001 << (b % 4);
            chk_cnt++;
            if (!ok || d !== 8'(8'h10 + (b % 4)))
                $display("FAIL rr_byte%0d: ok=%b got %h want %h", b, ok, d, 8'(8'h10 + (b % 4)));
            else pass_cnt++;
            chk_cnt++;
            if (g !== eg) $display("FAIL rr_gnt%0d: got %b want %b", b, g, eg);
            else pass_cnt++;
        end
        wait_idle();
    endtask

    task automatic test_lock();
        logic ok; logic [3:0] a; logic [3:0] g; logic [7:0] d;
        int txc;
        bus.lock = 4'b0100;
        bus.req  = 4'b0100;
        for (int b = 0; b < 3; b++) begin
            wait_ack(ok, a, g, d);
            if (b == 0) bus.req = 4'b1111;
            if (b == 2) bus.lock = 4'b0000;
            chk_cnt++;
            if (!ok || a !== 4'b0100) $display("FAIL lock_byte%0d: ok=%b ack got %b want 0100", b, ok, a);
            else pass_cnt++;
        end
        wait_ack(ok, a, g, d);
        bus.req = 4'b0000;
        chk_cnt++;
        if (!ok || a !== 4'b1000) $display("FAIL lock_after_release: ok=%b ack got %b want 1000", ok, a);
        else pass_cnt++;
        wait_idle();
        // Owner holds lock with req low: everyone else must be blocked.
        bus.lock = 4'b0100;
        bus.req  = 4'b0100;
        wait_ack(ok, a, g, d);
        bus.req = 4'b1011;
        chk_cnt++;
        if (!ok || a !== 4'b0100) $display("FAIL lock_hold_first: ok=%b ack got %b want 0100", ok, a);
        else pass_cnt++;
        txc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tx_external) txc++;
        end
        chk_cnt++;
        if (txc != 0) $display("FAIL lock_blocks_others: got %0d starts want 0", txc);
        else pass_cnt++;
        bus.lock = 4'b0000;
        wait_ack(ok, a, g, d);
        bus.req = 4'b0000;
        chk_cnt++;
        if (!ok || a !== 4'b1000) $display("FAIL lock_drop_release: ok=%b ack got %b want 1000", ok, a);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_drop();
        logic ok; logic [3:0] a; logic [3:0] g; logic [7:0] d;
        int txc;
        bus.req_data[7:0] = 8'h33;
        bus.req = 4'b0001;
        wait_ack(ok, a, g, d);
        bus.req = 4'b0000;
        bus.req_data[7:0] = 8'hFF;
        chk_cnt++;
        if (!ok || d !== 8'h33) $display("FAIL drop_first: ok=%b data got %h want 33", ok, d);
        else pass_cnt++;
        txc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.tx_external || bus.byte_ack != 4'b0) txc++;
        end
        chk_cnt++;
        if (txc != 0) $display("FAIL drop_no_second: got %0d extra acks want 0", txc);
        else pass_cnt++;
        chk_cnt++;
        if (bus.gnt !== 4'b0 || bus.state_out !== 2'd0 || bus.to_uart !== 8'h33)
            $display("FAIL drop_final: gnt=%b st=%0d to_uart=%h want 0000 0 33",
                     bus.gnt, bus.state_out, bus.to_uart);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic ok; logic [3:0] a; logic [3:0] g; logic [7:0] d;
        int found;
        busy_en = 1'b0;
        bus.lock = 4'b0010;
        bus.req  = 4'b0010;
        wait_ack(ok, a, g, d);
        bus.req = 4'b0000;
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.err) begin found = k; break; end
        end
        chk_cnt++;
        if (!ok || found != 16) $display("FAIL timeout_delay: ok=%b err after %0d cycles want 16", ok, found);
        else pass_cnt++;
        chk_cnt++;
        if (bus.state_out !== 2'd0 || bus.gnt !== 4'b0)
            $display("FAIL timeout_idle: st=%0d gnt=%b want 0 0000", bus.state_out, bus.gnt);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.err !== 1'b0) $display("FAIL timeout_pulse: err got %b want 0", bus.err);
        else pass_cnt++;
        // lock[1] still high with req[1] low: served only if the lock was cleared.
        busy_en = 1'b1;
        bus.req = 4'b0001;
        wait_ack(ok, a, g, d);
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        chk_cnt++;
        if (!ok || a !== 4'b0001) $display("FAIL timeout_next: ok=%b ack got %b want 0001", ok, a);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic ok; logic [3:0] a; logic [3:0] g; logic [7:0] d;
        int txc;
        bus.req_data[7:0] = 8'h44;
        bus.req = 4'b0001;
        wait_ack(ok, a, g, d);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (bus.state_out !== 2'd3) $display("FAIL mid_wait_idle: st got %0d want 3", bus.state_out);
        else pass_cnt++;
        busy_force = 1'b1;
        busy_en = 1'b0;
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.gnt, bus.byte_ack, bus.to_uart, bus.tx_external, bus.err, bus.state_out} !== 20'h0)
            $display("FAIL mid_reset_outputs: gnt=%b ack=%b to_uart=%h tx=%b err=%b st=%0d want all 0",
                     bus.gnt, bus.byte_ack, bus.to_uart, bus.tx_external, bus.err, bus.state_out);
        else pass_cnt++;
        bus.req = 4'b0010;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        txc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.tx_external || bus.gnt != 4'b0) txc++;
        end
        chk_cnt++;
        if (txc != 0) $display("FAIL mid_wait_busy: got %0d grant cycles want 0", txc);
        else pass_cnt++;
        busy_force = 1'b0;
        busy_en = 1'b1;
        wait_ack(ok, a, g, d);
        bus.req = 4'b0000;
        chk_cnt++;
        if (!ok || a !== 4'b0010 || g !== 4'b0010)
            $display("FAIL mid_grant: ok=%b ack=%b gnt=%b want 0010", ok, a, g);
        else pass_cnt++;
        wait_idle();
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        busy_m = 1'b0; busy_force = 1'b0; busy_en = 1'b1; bcnt = 0; pend = 1'b0;
        bus.req = '0; bus.lock = '0; bus.req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_drop();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
